// File: rtl/logarithm_pkg.sv
// Shared types and constants for the integer-logarithm engine.
package logarithm_pkg;
  localparam int DEFAULT_WIDTH = 32;
  localparam int MUL_CYCLES    = DEFAULT_WIDTH;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MUL  = 3'd2,
    CMP  = 3'd3,
    DONE = 3'd4
  } log_state_t;
endpackage

// File: rtl/seq_multiplier.sv
// Shift-add unsigned multiplier, one multiplier bit per cycle.
// The start edge already consumes bit 0, so done rises on the WIDTH-th edge.
module seq_multiplier #(
  parameter int W = 32
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           start,
  input  logic [W-1:0]   mcand,
  input  logic [W-1:0]   mplier,
  output logic [2*W-1:0] prod,
  output logic           done
);
  localparam int CW = $clog2(W) + 1;

  logic [2*W-1:0] mc;
  logic [W-1:0]   mp;
  logic [CW-1:0]  bits;
  logic           busy;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      prod <= '0;
      mc   <= '0;
      mp   <= '0;
      bits <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      prod <= mplier[0] ? {{W{1'b0}}, mcand} : '0;
      mc   <= {{W{1'b0}}, mcand} << 1;
      mp   <= mplier >> 1;
      bits <= CW'(1);
      busy <= (W > 1);
      done <= (W == 1);
    end else if (busy) begin
      prod <= prod + (mp[0] ? mc : '0);
      mc   <= mc << 1;
      mp   <= mp >> 1;
      bits <= bits + CW'(1);
      if (bits == CW'(W - 1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/logarithm_accelerator.sv
// floor(log_x(p)) by repeated multiplication: acc walks 1, x, x^2, ... while <= p.
// Overflow into the high product half ends the search, so wrap-around never counts.
module logarithm_accelerator
  import logarithm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] a,
  output logic             ready,
  output logic             exact,
  output logic             err
);
  log_state_t         state;
  logic [WIDTH-1:0]   xr, pr, acc, cnt;
  logic [2*WIDTH-1:0] prod;
  logic               mul_done, mul_start;
  logic [WIDTH-1:0]   mcand;
  logic               bad, stop;

  assign bad  = (xr < WIDTH'(2)) || (pr == '0);
  assign stop = (|prod[2*WIDTH-1:WIDTH]) || (prod[WIDTH-1:0] > pr);

  // The multiplier is launched on the same edge acc is updated, so feed it the
  // value acc is about to take rather than the register itself.
  assign mul_start = ((state == LOAD) && !bad) || ((state == CMP) && !stop);
  assign mcand     = (state == LOAD) ? WIDTH'(1) : prod[WIDTH-1:0];

  seq_multiplier #(.W(WIDTH)) u_mul (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (mul_start),
    .mcand   (mcand),
    .mplier  (xr),
    .prod    (prod),
    .done    (mul_done)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      xr    <= '0;
      pr    <= '0;
      acc   <= '0;
      cnt   <= '0;
      a     <= '0;
      ready <= 1'b0;
      exact <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (enable) begin
            xr    <= x;
            pr    <= p;
            ready <= 1'b0;
            exact <= 1'b0;
            err   <= 1'b0;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (bad) begin
            err   <= 1'b1;
            a     <= '0;
            exact <= 1'b0;
            ready <= 1'b1;
            state <= DONE;
          end else begin
            acc   <= WIDTH'(1);
            cnt   <= '0;
            state <= MUL;
          end
        end
        MUL: begin
          if (mul_done) state <= CMP;
        end
        CMP: begin
          if (stop) begin
            a     <= cnt;
            exact <= (acc == pr);
            ready <= 1'b1;
            state <= DONE;
          end else begin
            acc   <= prod[WIDTH-1:0];
            cnt   <= cnt + WIDTH'(1);
            state <= MUL;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_logarithm_accelerator.sv
// Directed-vector bench for logarithm_accelerator: latency, result, exact/err flags.
module tb_logarithm_accelerator;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] x = '0, p = '0;
  logic [31:0] a;
  logic        ready, exact, err;

  int applied = 0;
  int bad_cnt = 0;

  logarithm_accelerator #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (enable),
    .x       (x),
    .p       (p),
    .a       (a),
    .ready   (ready),
    .exact   (exact),
    .err     (err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] x;
    logic [31:0] p;
    logic [31:0] a;
    logic        exact;
    logic        err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    applied++;
    if (got !== want) begin
      bad_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Wait (from #1 after an edge) for ready, returning edges elapsed; -1 on timeout.
  task automatic wait_ready(output int lat);
    lat = -1;
    for (int n = 1; n <= 2000; n++) begin
      @(posedge clock);
      #1;
      if (ready) begin
        lat = n;
        break;
      end
    end
  endtask

  // Called at #1 after an edge; the following edge is E0.
  task automatic run(input vec_t v, input string tag);
    int lat, want_lat;
    want_lat = v.err ? 1 : 1 + 33 * (int'(v.a) + 1);
    enable = 1'b1; x = v.x; p = v.p;
    @(posedge clock);
    #1;
    enable = 1'b0;
    check({tag, " ready_clear"}, {31'b0, ready}, 32'd0);
    wait_ready(lat);
    check({tag, " latency"}, lat, want_lat);
    check({tag, " a"}, a, v.a);
    check({tag, " exact"}, {31'b0, exact}, {31'b0, v.exact});
    check({tag, " err"}, {31'b0, err}, {31'b0, v.err});
  endtask

  vec_t vecs[11];

  initial begin
    int lat;
    vec_t v5;
    vecs[0]  = '{32'd5,        32'd3125,       32'd5,  1'b1, 1'b0};
    vecs[1]  = '{32'd5,        32'd3124,       32'd4,  1'b0, 1'b0};
    vecs[2]  = '{32'd3,        32'd1,          32'd0,  1'b1, 1'b0};
    vecs[3]  = '{32'd2,        32'hFFFFFFFF,   32'd31, 1'b0, 1'b0};
    vecs[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF,   32'd1,  1'b1, 1'b0};
    vecs[5]  = '{32'd2,        32'h80000000,   32'd31, 1'b1, 1'b0};
    vecs[6]  = '{32'd1,        32'd50,         32'd0,  1'b0, 1'b1};
    vecs[7]  = '{32'd0,        32'd7,          32'd0,  1'b0, 1'b1};
    vecs[8]  = '{32'd7,        32'd0,          32'd0,  1'b0, 1'b1};
    vecs[9]  = '{32'd10,       32'd999,        32'd2,  1'b0, 1'b0};
    vecs[10] = '{32'd7,        32'd49,         32'd2,  1'b1, 1'b0};
    v5 = vecs[0];

    repeat (3) @(posedge clock);
    #1;
    check("reset a", a, 32'd0);
    check("reset ready", {31'b0, ready}, 32'd0);
    check("reset exact", {31'b0, exact}, 32'd0);
    check("reset err", {31'b0, err}, 32'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Vectors run back-to-back: each start lands in the first DONE cycle.
    for (int i = 0; i < 11; i++) run(vecs[i], $sformatf("vec%0d", i));

    // enable and operand changes during MUL are ignored.
    @(posedge clock);
    #1;
    enable = 1'b1; x = 32'd5; p = 32'd3125;
    @(posedge clock);
    #1;
    enable = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    enable = 1'b1; x = 32'd2; p = 32'd7;
    @(posedge clock);
    #1;
    enable = 1'b0; x = 32'd3; p = 32'd9;
    wait_ready(lat);
    check("busy latency", lat + 11, 199);
    check("busy a", a, 32'd5);
    check("busy exact", {31'b0, exact}, 32'd1);

    // Reset in the middle of a multiply.
    @(posedge clock);
    #1;
    enable = 1'b1; x = 32'd5; p = 32'd3125;
    @(posedge clock);
    #1;
    enable = 1'b0;
    repeat (15) @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    check("midrst a", a, 32'd0);
    check("midrst ready", {31'b0, ready}, 32'd0);
    check("midrst exact", {31'b0, exact}, 32'd0);
    check("midrst err", {31'b0, err}, 32'd0);
    repeat (250) @(posedge clock);
    #1;
    check("midrst idle", {31'b0, ready}, 32'd0);
    run(v5, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", applied, bad_cnt);
    $finish;
  end
endmodule
